// File: rtl/sd_cmd_pkg.sv
// Shared command constants, error codes, step/state encodings and per-step command settings
// for the SD-card identification sequencer.
package sd_cmd_pkg;

  localparam logic [5:0] CMD0_INDEX   = 6'd0;
  localparam logic [5:0] CMD8_INDEX   = 6'd8;
  localparam logic [5:0] CMD55_INDEX  = 6'd55;
  localparam logic [5:0] ACMD41_INDEX = 6'd41;
  localparam logic [5:0] CMD2_INDEX   = 6'd2;
  localparam logic [5:0] CMD3_INDEX   = 6'd3;

  localparam logic [31:0] CMD8_ARG         = 32'h0000_01AA;
  localparam logic [11:0] CMD8_ECHO        = 12'h1AA;
  localparam logic [31:0] ACMD41_ARG_HCS   = 32'h40FF_8000;
  localparam logic [31:0] ACMD41_ARG_SDSC  = 32'h00FF_8000;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_CMD0_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_CMD8_BAD      = 3'd2;
  localparam logic [2:0] ERR_CMD55_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_ACMD41        = 3'd4;
  localparam logic [2:0] ERR_CMD2_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_CMD3_TIMEOUT  = 3'd6;
  localparam logic [2:0] ERR_INDEX         = 3'd7;

  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3
  } sdStep_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_EVAL, ST_DELAY, ST_DONE, ST_ERROR
  } sdState_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_PULSE, PH_WAIT
  } issuePhase_t;

  // Command index carried by each step.
  function automatic logic [5:0] stepIndex(input sdStep_t step);
    case (step)
      STEP_CMD0:   return CMD0_INDEX;
      STEP_CMD8:   return CMD8_INDEX;
      STEP_CMD55:  return CMD55_INDEX;
      STEP_ACMD41: return ACMD41_INDEX;
      STEP_CMD2:   return CMD2_INDEX;
      default:     return CMD3_INDEX;
    endcase
  endfunction

  // Argument for each step; ACMD41 only advertises HCS to a v2 card.
  function automatic logic [31:0] stepArgument(input sdStep_t step, input logic cardV2);
    case (step)
      STEP_CMD8:   return CMD8_ARG;
      STEP_ACMD41: return cardV2 ? ACMD41_ARG_HCS : ACMD41_ARG_SDSC;
      default:     return 32'h0;
    endcase
  endfunction

  // CMD0 has no response, so it is the only command issued without a timeout.
  function automatic logic stepTimeoutEnable(input sdStep_t step);
    return step != STEP_CMD0;
  endfunction

endpackage

// File: rtl/sd_cmd_issue.sv
// Issue/wait handshake with the command controller: one-cycle issue pulse, command fields held
// until the command resolves, then a one-cycle result strobe with sticky result flags.
module sd_cmd_issue
  import sd_cmd_pkg::*;
(
  input  logic        iClock_SD_Host,
  input  logic        iReset,
  input  logic        iLaunch,
  input  logic [5:0]  iIndex,
  input  logic [31:0] iArgument,
  input  logic        iTimeoutEnable,
  input  logic        iCommand_complete,
  input  logic        iCommand_index_error,
  input  logic        iTimeout,
  input  logic [31:0] iResponse,
  output logic        oNew_command,
  output logic [5:0]  oCmd_index,
  output logic [31:0] oCmd_argument,
  output logic        oTimeout_enable,
  output logic        oResultValid,
  output logic        oResultTimeout,
  output logic        oResultIndexError,
  output logic [31:0] oResultData
);

  issuePhase_t phase;

  // Launch a command, hold it through the wait, and resolve completion with timeout taking priority.
  always_ff @(posedge iClock_SD_Host) begin
    if (iReset) begin
      phase             <= PH_IDLE;
      oNew_command      <= 1'b0;
      oCmd_index        <= 6'd0;
      oCmd_argument     <= 32'h0;
      oTimeout_enable   <= 1'b0;
      oResultValid      <= 1'b0;
      oResultTimeout    <= 1'b0;
      oResultIndexError <= 1'b0;
      oResultData       <= 32'h0;
    end else begin
      oNew_command <= 1'b0;
      oResultValid <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (iLaunch) begin
            phase           <= PH_PULSE;
            oNew_command    <= 1'b1;
            oCmd_index      <= iIndex;
            oCmd_argument   <= iArgument;
            oTimeout_enable <= iTimeoutEnable;
          end
        end
        PH_PULSE: phase <= PH_WAIT;
        PH_WAIT: begin
          if (iTimeout || iCommand_complete) begin
            phase             <= PH_IDLE;
            oResultValid      <= 1'b1;
            oResultTimeout    <= iTimeout;
            oResultIndexError <= !iTimeout && iCommand_index_error;
            oResultData       <= iResponse;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sd_init_sequencer.sv
// SD-card identification sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3.
// Captures the card capacity class and RCA, reports the abort cause on failure.
module sd_init_sequencer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned MAX_ACMD41_TRIES   = 1000,
  parameter int unsigned RETRY_DELAY_CYCLES = 4000,
  parameter int unsigned CNT_W              = 16
) (
  input  logic         iClock_SD_Host,
  input  logic         iReset,
  input  logic         iStart,
  input  logic         iCommand_complete,
  input  logic         iCommand_index_error,
  input  logic         iTimeout,
  input  logic [127:0] iResponse,
  output logic         oNew_command,
  output logic [5:0]   oCmd_index,
  output logic [31:0]  oCmd_argument,
  output logic         oTimeout_enable,
  output logic         oBusy,
  output logic         oInit_done,
  output logic         oInit_error,
  output logic [2:0]   oError_code,
  output logic         oCard_hcs,
  output logic [15:0]  oRca
);

  sdState_t         state;
  sdStep_t          step;
  logic             cardV2;
  logic [CNT_W-1:0] retryCount;
  logic [CNT_W-1:0] delayCount;

  logic        resultValid;
  logic        resultTimeout;
  logic        resultIndexError;
  logic [31:0] resultData;

  logic             evalGo_c;
  sdStep_t          evalStep_c;
  logic             evalFail_c;
  logic [2:0]       evalCode_c;
  logic             evalDelay_c;
  logic             evalFinish_c;
  logic [CNT_W-1:0] retryNext_c;
  logic             delayDone_c;
  logic             launch_c;
  sdStep_t          launchStep_c;
  logic [5:0]       launchIndex_c;
  logic [31:0]      launchArgument_c;
  logic             launchTimeoutEnable_c;

  logic unusedResponseBits;
  assign unusedResponseBits = ^{iResponse[127:32], resultData[15:12]};

  assign delayDone_c           = (32'(delayCount) + 32'd1) >= RETRY_DELAY_CYCLES;
  assign launchIndex_c         = stepIndex(launchStep_c);
  assign launchArgument_c      = stepArgument(launchStep_c, cardV2);
  assign launchTimeoutEnable_c = stepTimeoutEnable(launchStep_c);

  sd_cmd_issue uIssue (
    .iClock_SD_Host       (iClock_SD_Host),
    .iReset               (iReset),
    .iLaunch              (launch_c),
    .iIndex               (launchIndex_c),
    .iArgument            (launchArgument_c),
    .iTimeoutEnable       (launchTimeoutEnable_c),
    .iCommand_complete    (iCommand_complete),
    .iCommand_index_error (iCommand_index_error),
    .iTimeout             (iTimeout),
    .iResponse            (iResponse[31:0]),
    .oNew_command         (oNew_command),
    .oCmd_index           (oCmd_index),
    .oCmd_argument        (oCmd_argument),
    .oTimeout_enable      (oTimeout_enable),
    .oResultValid         (resultValid),
    .oResultTimeout       (resultTimeout),
    .oResultIndexError    (resultIndexError),
    .oResultData          (resultData)
  );

  // Judge the held result of the current step: next step, retry delay, finish or abort cause.
  always_comb begin
    evalGo_c     = 1'b0;
    evalStep_c   = step;
    evalFail_c   = 1'b0;
    evalCode_c   = ERR_NONE;
    evalDelay_c  = 1'b0;
    evalFinish_c = 1'b0;
    retryNext_c  = retryCount + CNT_W'(1);
    if (resultTimeout) begin
      case (step)
        STEP_CMD8:   begin evalGo_c = 1'b1; evalStep_c = STEP_CMD55; end
        STEP_CMD0:   begin evalFail_c = 1'b1; evalCode_c = ERR_CMD0_TIMEOUT; end
        STEP_CMD55:  begin evalFail_c = 1'b1; evalCode_c = ERR_CMD55_TIMEOUT; end
        STEP_ACMD41: begin evalFail_c = 1'b1; evalCode_c = ERR_ACMD41; end
        STEP_CMD2:   begin evalFail_c = 1'b1; evalCode_c = ERR_CMD2_TIMEOUT; end
        default:     begin evalFail_c = 1'b1; evalCode_c = ERR_CMD3_TIMEOUT; end
      endcase
    end else if (resultIndexError &&
                 (step == STEP_CMD8 || step == STEP_CMD55 || step == STEP_CMD3)) begin
      evalFail_c = 1'b1;
      evalCode_c = ERR_INDEX;
    end else begin
      case (step)
        STEP_CMD0: begin evalGo_c = 1'b1; evalStep_c = STEP_CMD8; end
        STEP_CMD8: begin
          if (resultData[11:0] == CMD8_ECHO) begin
            evalGo_c   = 1'b1;
            evalStep_c = STEP_CMD55;
          end else begin
            evalFail_c = 1'b1;
            evalCode_c = ERR_CMD8_BAD;
          end
        end
        STEP_CMD55: begin evalGo_c = 1'b1; evalStep_c = STEP_ACMD41; end
        STEP_ACMD41: begin
          if (resultData[31]) begin
            evalGo_c   = 1'b1;
            evalStep_c = STEP_CMD2;
          end else if (retryNext_c == CNT_W'(MAX_ACMD41_TRIES)) begin
            evalFail_c = 1'b1;
            evalCode_c = ERR_ACMD41;
          end else begin
            evalDelay_c = 1'b1;
          end
        end
        STEP_CMD2: begin evalGo_c = 1'b1; evalStep_c = STEP_CMD3; end
        default:   evalFinish_c = 1'b1;
      endcase
    end
  end

  // Decide whether a command launches on this edge and which step it belongs to.
  always_comb begin
    launch_c     = 1'b0;
    launchStep_c = STEP_CMD0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: launch_c = iStart;
      ST_EVAL: begin
        if (evalGo_c) begin
          launch_c     = 1'b1;
          launchStep_c = evalStep_c;
        end
      end
      ST_DELAY: begin
        if (delayDone_c) begin
          launch_c     = 1'b1;
          launchStep_c = STEP_CMD55;
        end
      end
      default: launch_c = 1'b0;
    endcase
  end

  // Sequencer state, step, counters and host-visible status registers.
  always_ff @(posedge iClock_SD_Host) begin
    if (iReset) begin
      state       <= ST_IDLE;
      step        <= STEP_CMD0;
      cardV2      <= 1'b0;
      retryCount  <= '0;
      delayCount  <= '0;
      oBusy       <= 1'b0;
      oInit_done  <= 1'b0;
      oInit_error <= 1'b0;
      oError_code <= ERR_NONE;
      oCard_hcs   <= 1'b0;
      oRca        <= 16'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (launch_c) begin
            state       <= ST_ISSUE;
            step        <= launchStep_c;
            cardV2      <= 1'b0;
            retryCount  <= '0;
            oBusy       <= 1'b1;
            oInit_done  <= 1'b0;
            oInit_error <= 1'b0;
            oError_code <= ERR_NONE;
            oCard_hcs   <= 1'b0;
            oRca        <= 16'h0;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (resultValid) state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (step == STEP_CMD8) cardV2 <= !resultTimeout && (resultData[11:0] == CMD8_ECHO);
          if (step == STEP_ACMD41 && !resultTimeout && resultData[31]) oCard_hcs <= resultData[30];
          if (evalFail_c) begin
            state       <= ST_ERROR;
            oBusy       <= 1'b0;
            oInit_error <= 1'b1;
            oError_code <= evalCode_c;
          end else if (evalFinish_c) begin
            state      <= ST_DONE;
            oBusy      <= 1'b0;
            oInit_done <= 1'b1;
            oRca       <= resultData[31:16];
          end else if (evalDelay_c) begin
            state      <= ST_DELAY;
            retryCount <= retryNext_c;
            delayCount <= '0;
          end else if (launch_c) begin
            state <= ST_ISSUE;
            step  <= launchStep_c;
          end
        end
        ST_DELAY: begin
          if (launch_c) begin
            state <= ST_ISSUE;
            step  <= launchStep_c;
          end else if (delayCount != {CNT_W{1'b1}}) begin
            delayCount <= delayCount + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Self-checking bench for sd_init_sequencer: a card responder answers each issued command,
// and a protocol-level model predicts the command list and final status.
module tb_sd_init_sequencer;

  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned RDC       = 12;
  localparam int unsigned CNT_W     = 16;
  localparam int          BUDGET    = 4000;

  logic         Clock;
  logic         Reset;
  logic         start;
  logic         cmdComplete;
  logic         indexError;
  logic         timeout;
  logic [127:0] response;
  logic         newCommand;
  logic [5:0]   cmdIndex;
  logic [31:0]  cmdArgument;
  logic         timeoutEnable;
  logic         busy;
  logic         initDone;
  logic         initError;
  logic [2:0]   errorCode;
  logic         cardHcs;
  logic [15:0]  rca;

  sd_init_sequencer #(
    .MAX_ACMD41_TRIES   (MAX_TRIES),
    .RETRY_DELAY_CYCLES (RDC),
    .CNT_W              (CNT_W)
  ) dut (
    .iClock_SD_Host       (Clock),
    .iReset               (Reset),
    .iStart               (start),
    .iCommand_complete    (cmdComplete),
    .iCommand_index_error (indexError),
    .iTimeout             (timeout),
    .iResponse            (response),
    .oNew_command         (newCommand),
    .oCmd_index           (cmdIndex),
    .oCmd_argument        (cmdArgument),
    .oTimeout_enable      (timeoutEnable),
    .oBusy                (busy),
    .oInit_done           (initDone),
    .oInit_error          (initError),
    .oError_code          (errorCode),
    .oCard_hcs            (cardHcs),
    .oRca                 (rca)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // cmd8Mode: 0 echo 0x1AA, 1 no response, 2 wrong echo. faultKind: 1 timeout, 2 index error, 3 both.
  typedef struct {
    int        cmd8Mode;
    int        busyTries;
    bit        hcs;
    bit [15:0] rca;
    int        faultCmd;
    int        faultKind;
    bit        noise;
  } scen_t;

  typedef struct {
    scen_t     s;
    bit        done;
    bit        err;
    bit [2:0]  code;
    bit        hcs;
    bit [15:0] rca;
    int        pulses;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [38:0] expCmds[$];
  logic [38:0] actCmds[$];
  bit        mDone, mErr, mHcs;
  bit [2:0]  mCode;
  bit [15:0] mRca;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void addCmd(input int idx, input logic [31:0] arg, input bit te);
    expCmds.push_back({6'(idx), te, arg});
  endfunction

  function automatic bit isTo(input scen_t s, input int c);
    return s.faultCmd == c && (s.faultKind == 1 || s.faultKind == 3);
  endfunction

  function automatic bit isIdx(input scen_t s, input int c);
    return s.faultCmd == c && s.faultKind == 2;
  endfunction

  function automatic void fail(input int code);
    mErr  = 1'b1;
    mCode = 3'(code);
  endfunction

  // Walks the identification flow as a card/host conversation.
  function automatic void model(input scen_t s);
    bit v2;
    expCmds.delete();
    mDone = 0; mErr = 0; mCode = 0; mHcs = 0; mRca = 0;
    addCmd(0, 32'h0, 1'b0);
    if (isTo(s, 0)) begin fail(1); return; end
    addCmd(8, 32'h1AA, 1'b1);
    if (isTo(s, 8)) v2 = 0;
    else if (isIdx(s, 8)) begin fail(7); return; end
    else if (s.cmd8Mode == 1) v2 = 0;
    else if (s.cmd8Mode == 2) begin fail(2); return; end
    else v2 = 1;
    for (int a = 0; a < int'(MAX_TRIES); a++) begin
      addCmd(55, 32'h0, 1'b1);
      if (a == 0 && isTo(s, 55)) begin fail(3); return; end
      if (a == 0 && isIdx(s, 55)) begin fail(7); return; end
      addCmd(41, v2 ? 32'h40FF8000 : 32'h00FF8000, 1'b1);
      if (a == 0 && isTo(s, 41)) begin fail(4); return; end
      if (a >= s.busyTries) begin mHcs = s.hcs; break; end
      if (a + 1 == int'(MAX_TRIES)) begin fail(4); return; end
    end
    addCmd(2, 32'h0, 1'b1);
    if (isTo(s, 2)) begin fail(5); return; end
    addCmd(3, 32'h0, 1'b1);
    if (isTo(s, 3)) begin fail(6); return; end
    if (isIdx(s, 3)) begin fail(7); return; end
    mRca  = s.rca;
    mDone = 1;
  endfunction

  task automatic clearInputs();
    start = 0; cmdComplete = 0; indexError = 0; timeout = 0; response = '0;
  endtask

  // Pulses start and plays the card until the sequence ends (or until the first ACMD41 issue).
  task automatic runSeq(input scen_t s, input bit stopAt41);
    int cyc, lat, n41, lastAcmd, cnt[64];
    logic [5:0]  idx;
    logic [31:0] rsp;
    bit cc, to, ie, first;
    actCmds.delete();
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    n41 = 0; lastAcmd = -1; cyc = 0;
    @(negedge Clock); start = 1;
    @(negedge Clock); start = 0;
    check("first_pulse", {newCommand, busy, initDone, initError}, 4'b1100);
    check("first_cmd", {cmdIndex, timeoutEnable, cmdArgument}, 39'h0);
    while (1) begin
      if (cyc >= BUDGET) begin
        total++; bad++;
        $display("FAIL run_budget: got %0d cycles expected below %0d", cyc, BUDGET);
        return;
      end
      if (newCommand) begin
        idx = cmdIndex;
        actCmds.push_back({cmdIndex, timeoutEnable, cmdArgument});
        if (idx == 6'd41) begin
          if (lastAcmd >= 0) check("acmd41_gap", 64'(cyc - lastAcmd >= int'(RDC)), 64'd1);
          lastAcmd = cyc;
          if (stopAt41) return;
        end
        first = (cnt[idx] == 0);
        cnt[idx]++;
        cc = 1; to = 0; ie = 0; rsp = $urandom;
        case (idx)
          6'd8: begin
            if (s.cmd8Mode == 1) begin cc = 0; to = 1; end
            rsp = (s.cmd8Mode == 2) ? 32'h1AB : 32'h1AA;
          end
          6'd55: rsp = 32'h00000120;
          6'd41: begin
            rsp = (n41 < s.busyTries) ? 32'h00FF8000 : (s.hcs ? 32'hC0FF8000 : 32'h80FF8000);
            n41++;
          end
          6'd3: rsp = {s.rca, 16'h0500};
          default: ;
        endcase
        if (first && s.faultCmd == int'(idx)) begin
          if (s.faultKind == 1) begin to = 1; cc = 0; end
          else if (s.faultKind == 2) begin ie = 1; cc = 1; to = 0; end
          else begin to = 1; cc = 1; end
        end
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          @(negedge Clock); cyc++;
          start = s.noise && ($urandom_range(0, 1) == 1);
        end
        cmdComplete = cc; timeout = to; indexError = ie;
        response = {$urandom, $urandom, $urandom, rsp};
        @(negedge Clock); cyc++;
        clearInputs();
      end else if (!busy) begin
        return;
      end else begin
        @(negedge Clock); cyc++;
      end
    end
  endtask

  // Compares the final status against expectations and the command list against the model.
  task automatic finalCheck(input bit done, input bit err, input bit [2:0] code, input bit hcs,
                            input bit [15:0] r, input int pulses);
    check("busy_end", busy, 0);
    check("init_done", initDone, done);
    check("init_error", initError, err);
    check("error_code", errorCode, code);
    check("card_hcs", cardHcs, hcs);
    check("rca", rca, r);
    check("pulse_count", actCmds.size(), pulses);
    for (int i = 0; i < actCmds.size() && i < expCmds.size(); i++)
      check($sformatf("cmd%0d", i), actCmds[i], expCmds[i]);
  endtask

  // Stray handshake inputs while not busy must neither issue a command nor disturb status.
  task automatic quietCheck();
    logic [22:0] snap;
    int pulses;
    snap = {initDone, initError, errorCode, cardHcs, rca, busy};
    pulses = 0;
    repeat (20) begin
      @(negedge Clock);
      if (newCommand) pulses++;
      cmdComplete = ($urandom_range(0, 2) == 0);
      timeout     = ($urandom_range(0, 2) == 0);
      indexError  = ($urandom_range(0, 2) == 0);
      response    = {$urandom, $urandom, $urandom, $urandom};
    end
    clearInputs();
    @(negedge Clock);
    if (newCommand) pulses++;
    check("quiet_pulses", pulses, 0);
    check("quiet_status", {initDone, initError, errorCode, cardHcs, rca, busy}, snap);
  endtask

  vec_t  vecs[12];
  scen_t s;

  initial begin
    vecs[0]  = '{'{0, 2, 1, 16'h1234, -1, 0, 1}, 1, 0, 3'd0, 1, 16'h1234, 10};
    vecs[1]  = '{'{1, 0, 0, 16'h0001, -1, 0, 0}, 1, 0, 3'd0, 0, 16'h0001, 6};
    vecs[2]  = '{'{2, 0, 0, 16'h0000, -1, 0, 0}, 0, 1, 3'd2, 0, 16'h0000, 2};
    vecs[3]  = '{'{0, 7, 0, 16'h0000, -1, 0, 0}, 0, 1, 3'd4, 0, 16'h0000, 8};
    vecs[4]  = '{'{0, 0, 1, 16'hBEEF, 2, 3, 0},  0, 1, 3'd5, 1, 16'h0000, 5};
    vecs[5]  = '{'{0, 0, 0, 16'h0000, 55, 2, 1}, 0, 1, 3'd7, 0, 16'h0000, 3};
    vecs[6]  = '{'{0, 0, 0, 16'h0000, 0, 1, 0},  0, 1, 3'd1, 0, 16'h0000, 1};
    vecs[7]  = '{'{1, 1, 1, 16'h5555, 3, 2, 0},  0, 1, 3'd7, 1, 16'h0000, 8};
    vecs[8]  = '{'{0, 0, 1, 16'hA5A5, 41, 2, 0}, 1, 0, 3'd0, 1, 16'hA5A5, 6};
    vecs[9]  = '{'{0, 0, 0, 16'h0000, 55, 1, 0}, 0, 1, 3'd3, 0, 16'h0000, 3};
    vecs[10] = '{'{0, 0, 0, 16'h7777, 3, 1, 0},  0, 1, 3'd6, 0, 16'h0000, 6};
    vecs[11] = '{'{2, 0, 1, 16'h2222, 8, 1, 0},  1, 0, 3'd0, 1, 16'h2222, 6};

    clearInputs();
    Reset = 1;
    repeat (3) @(negedge Clock);
    check("reset_outputs", {newCommand, cmdIndex, cmdArgument, timeoutEnable, busy, initDone,
                            initError, errorCode, cardHcs, rca}, 64'h0);
    Reset = 0;
    quietCheck();

    for (int v = 0; v < 12; v++) begin
      model(vecs[v].s);
      runSeq(vecs[v].s, 0);
      finalCheck(vecs[v].done, vecs[v].err, vecs[v].code, vecs[v].hcs, vecs[v].rca, vecs[v].pulses);
      quietCheck();
    end

    // Reset while ACMD41 is outstanding, then a fresh start must begin again at CMD0.
    s = '{0, 0, 1, 16'h4321, -1, 0, 0};
    runSeq(s, 1);
    @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    check("reset_in_wait", {newCommand, cmdIndex, cmdArgument, timeoutEnable, busy, initDone,
                            initError, errorCode, cardHcs, rca}, 64'h0);
    Reset = 0;
    quietCheck();
    s = '{1, 1, 0, 16'h0BAD, -1, 0, 0};
    model(s);
    runSeq(s, 0);
    finalCheck(mDone, mErr, mCode, mHcs, mRca, expCmds.size());

    for (int r = 0; r < 30; r++) begin
      s.cmd8Mode  = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
      s.busyTries = $urandom_range(0, 3);
      s.hcs       = 1'($urandom_range(0, 1));
      s.rca       = 16'($urandom);
      case ($urandom_range(0, 11))
        0: s.faultCmd = 0;
        1: s.faultCmd = 8;
        2: s.faultCmd = 55;
        3: s.faultCmd = 41;
        4: s.faultCmd = 2;
        5: s.faultCmd = 3;
        default: s.faultCmd = -1;
      endcase
      s.faultKind = $urandom_range(1, 3);
      s.noise     = 1'($urandom_range(0, 1));
      model(s);
      runSeq(s, 0);
      finalCheck(mDone, mErr, mCode, mHcs, mRca, expCmds.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
